rd_ex_hazard_ctrl: RTL and testbench
====================================

// Module: rd_ex_hazard_ctrl
// PURPOSE
//   Stall/flush controller and LM/SM micro-op sequencer for the RD->EX pipeline register.
//   - Detects load-use hazards and branch redirects; drives PC/IF-ID holds and RD/EX bubble insertion.
//   - Expands LM/SM into one register micro-op per cycle, so the RD/EX register sees one register per cycle.
// PARAMETERS
//   REG_AW   3   register-index width
//   NUM_REGS 8   architectural registers = LM/SM reglist width
//   CNT_W    16  perf-counter width (used only with PIPE_CTRL_PERF_EN)
// PORTS
//   clk             in  1        single clock; all state updates on rising edge
//   rst_n           in  1        reset, asynchronous, active-low
//   id_valid        in  1        valid instruction in RD stage
//   id_opcode       in  4        RD opcode; LM=4'b0110, SM=4'b0111
//   id_rs1,id_rs2   in  REG_AW   RD source registers
//   id_use_rs1/rs2  in  1        RD instruction actually reads rs1/rs2
//   id_reglist      in  NUM_REGS LM/SM register mask (imm[7:0])
//   ex_memread      in  1        EX holds a load
//   ex_regwrite     in  1        EX writes a register
//   ex_regdst       in  REG_AW   EX destination register
//   ex_br_taken     in  1        branch/jump resolved taken in EX
//   stall_pc        out 1        hold PC and IF/ID
//   bubble_ex       out 1        load zero controls into RD/EX next edge
//   flush_id        out 1        invalidate IF/ID next edge
//   lmsm_active     out 1        RD/EX is loaded with an LM/SM micro-op
//   lmsm_reg        out REG_AW   register for the current micro-op
//   lmsm_offset     out 4        word offset of the current micro-op from the base address (0..7)
//   lmsm_last       out 1        current micro-op is the final one
//   stall_cnt       out CNT_W    stall-cycle counter
//   flush_cnt       out CNT_W    flush-event counter
// BEHAVIOUR
//   - FSM states: IDLE, SEQ. Internal state: mask[NUM_REGS-1:0], offset[3:0].
//   - Reset (async): state=IDLE, mask=0, offset=0; every output=0 while rst_n=0.
//   - Hazard terms (combinational, evaluated every cycle):
//     - lu = id_valid & ex_memread & ex_regwrite & ((id_use_rs1 & id_rs1==ex_regdst) | (id_use_rs2 & id_rs2==ex_regdst))
//   - Priority: ex_br_taken > lu > LM/SM start.
//   - ex_br_taken, any state:
//     - Outputs: flush_id=1, bubble_ex=1, stall_pc=0, lmsm_active=0.
//     - Next edge: state=IDLE, mask=0, offset=0; an in-flight LM/SM is aborted.
//   - IDLE, lu: stall_pc=1, bubble_ex=1 for exactly one cycle; no state change.
//   - IDLE, LM/SM opcode, reglist!=0: stall_pc=1, bubble_ex=1; next edge: mask<=reglist, offset<=0, state<=SEQ.
//   - IDLE, LM/SM opcode, reglist==0: bubble_ex=1 for one cycle, stall_pc=0; no micro-ops.
//   - SEQ, each cycle:
//     - lmsm_active=1, lmsm_reg=index of lowest set bit of mask, lmsm_offset=offset.
//     - lmsm_last=(mask has exactly one bit set), stall_pc=~lmsm_last.
//     - Next edge: clear that bit, offset+1; if lmsm_last, state<=IDLE.
//   - Latency: N set bits occupy RD for N+1 cycles and issue N micro-ops back to back.
//   - No load-use check in SEQ (the RD instruction is the LM/SM itself).
//   - The first IDLE cycle after SEQ is checked normally.
//   - offset never wraps: maximum value 7 with NUM_REGS=8.
// CONFIGURATION
//   PIPE_CTRL_PERF_EN defined:
//     - stall_cnt increments on every cycle with stall_pc=1 or (bubble_ex & ~flush_id).
//     - flush_cnt increments on every flush_id cycle.
//     - Both saturate at all-ones; both reset to 0.
//   PIPE_CTRL_PERF_EN undefined: counters are not built; stall_cnt=flush_cnt=0 constant; ports remain.
// STRUCTURE
//   - Package iitb_pipe_pkg: opcode constants OP_LM/OP_SM, FSM state encoding, REG_AW/NUM_REGS defaults.
//   - Sub-module lsb_prio_enc: NUM_REGS-bit lowest-set-bit encoder producing index, valid and onehot_only.
//   - Everything else (FSM, hazard logic, counters) is flat in this module.
// TESTING
//   1. EX: LW, regdst=3, memread=1. ID: ADD, rs1=3, use_rs1=1.
//      -> stall_pc=bubble_ex=1 for one cycle, then 0; ADD proceeds.
//   2. LM reglist=8'b1000_0101.
//      -> c0: stall_pc=1, bubble_ex=1.
//      -> c1: reg=0, off=0, stall_pc=1.
//      -> c2: reg=2, off=1, stall_pc=1.
//      -> c3: reg=7, off=2, last=1, stall_pc=0.
//      -> c4: IDLE, lmsm_active=0.
//   3. SM reglist=0 -> one cycle bubble_ex=1, stall_pc=0; lmsm_active never asserts.
//   4. LM reglist=8'hFF with ex_br_taken=1 at the 2nd micro-op.
//      -> that cycle flush_id=1, bubble_ex=1, stall_pc=0; next cycle IDLE, mask=0.
//   5. ex_br_taken and lu in the same cycle -> flush wins: flush_id=1, stall_pc=0.
//      rst_n low mid-SEQ -> all outputs 0 immediately; after release, IDLE.
//   6. With PIPE_CTRL_PERF_EN: 3 lu stalls + 1 flush -> stall_cnt=3, flush_cnt=1;
//      preload near max -> holds 16'hFFFF. Without the macro: both read 0.

Source files
------------

// File: rtl/iitb_pipe_pkg.sv
// Shared constants for the RD->EX hazard controller: LM/SM opcodes, FSM state
// encoding and default register-file geometry.
package iitb_pipe_pkg;

    localparam int REG_AW_DEF   = 3;
    localparam int NUM_REGS_DEF = 8;
    localparam int CNT_W_DEF    = 16;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } fsm_state_e;

    function automatic logic is_lmsm(input logic [3:0] opcode);
        return (opcode == OP_LM) || (opcode == OP_SM);
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit encoder: index of the lowest set bit, whether any bit is set,
// and whether exactly one bit is set.
module lsb_prio_enc #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic [N-1:0]  i_mask,
    output logic [AW-1:0] o_index,
    output logic          o_valid,
    output logic          o_onehot_only
);

    logic w_found;

    // Scan upward; the first set bit found latches the index.
    always_comb begin
        o_index = {AW{1'b0}};
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            o_index = (i_mask[i] && !w_found) ? AW'(i) : o_index;
            w_found = w_found | i_mask[i];
        end
    end

    assign o_valid       = |i_mask;
    assign o_onehot_only = o_valid && ((i_mask & (i_mask - N'(1))) == {N{1'b0}});

endmodule

// File: rtl/rd_ex_hazard_ctrl.sv
// RD->EX stall/flush controller with LM/SM micro-op sequencer.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
import iitb_pipe_pkg::*;

module rd_ex_hazard_ctrl #(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [3:0]          id_opcode,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [NUM_REGS-1:0] id_reglist,
    input  logic                ex_memread,
    input  logic                ex_regwrite,
    input  logic [REG_AW-1:0]   ex_regdst,
    input  logic                ex_br_taken,
    output logic                stall_pc,
    output logic                bubble_ex,
    output logic                flush_id,
    output logic                lmsm_active,
    output logic [REG_AW-1:0]   lmsm_reg,
    output logic [3:0]          lmsm_offset,
    output logic                lmsm_last,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    fsm_state_e          r_state;
    logic [NUM_REGS-1:0] r_mask;
    logic [3:0]          r_offset;

    logic [REG_AW-1:0]   w_idx;
    logic                w_valid;
    logic                w_one;
    logic                w_last;
    logic                w_lu;
    logic                w_is_lmsm;
    logic                w_start;

    lsb_prio_enc #(.N(NUM_REGS), .AW(REG_AW)) u_enc (
        .i_mask        (r_mask),
        .o_index       (w_idx),
        .o_valid       (w_valid),
        .o_onehot_only (w_one)
    );

    // An empty mask in SEQ is treated as the final micro-op so the FSM cannot stick.
    assign w_last    = w_one | ~w_valid;
    assign w_lu      = id_valid & ex_memread & ex_regwrite &
                       ((id_use_rs1 & (id_rs1 == ex_regdst)) |
                        (id_use_rs2 & (id_rs2 == ex_regdst)));
    assign w_is_lmsm = id_valid & is_lmsm(id_opcode);
    assign w_start   = w_is_lmsm & (|id_reglist);

    // Control outputs: branch flush beats load-use beats LM/SM start; all zero in reset.
    always_comb begin
        stall_pc    = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        lmsm_active = 1'b0;
        lmsm_reg    = {REG_AW{1'b0}};
        lmsm_offset = 4'd0;
        lmsm_last   = 1'b0;
        if (!rst_n) begin
            stall_pc = 1'b0;
        end else if (ex_br_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else begin
            case (r_state)
                ST_SEQ: begin
                    lmsm_active = 1'b1;
                    lmsm_reg    = w_idx;
                    lmsm_offset = r_offset;
                    lmsm_last   = w_last;
                    stall_pc    = ~w_last;
                end
                ST_IDLE: begin
                    if (w_lu || w_start) begin
                        stall_pc  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (w_is_lmsm) begin
                        bubble_ex = 1'b1;
                    end else begin
                        bubble_ex = 1'b0;
                    end
                end
                default: begin
                    bubble_ex = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state: mask of remaining registers and word offset of the next micro-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mask   <= {NUM_REGS{1'b0}};
            r_offset <= 4'd0;
        end else if (ex_br_taken) begin
            r_state  <= ST_IDLE;
            r_mask   <= {NUM_REGS{1'b0}};
            r_offset <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_lu && w_start) begin
                        r_state  <= ST_SEQ;
                        r_mask   <= id_reglist;
                        r_offset <= 4'd0;
                    end
                end
                ST_SEQ: begin
                    if (w_last) begin
                        r_state  <= ST_IDLE;
                        r_mask   <= {NUM_REGS{1'b0}};
                        r_offset <= 4'd0;
                    end else begin
                        r_mask   <= r_mask & (r_mask - NUM_REGS'(1));
                        r_offset <= r_offset + 4'd1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mask   <= {NUM_REGS{1'b0}};
                    r_offset <= 4'd0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating stall-cycle and flush-event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if ((stall_pc || (bubble_ex && !flush_id)) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush_id && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rd_ex_hazard_ctrl.sv
// Table-driven, scoreboarded bench for rd_ex_hazard_ctrl.
module tb_rd_ex_hazard_ctrl;

    localparam logic [3:0] OPC_ADD = 4'b0000;
    localparam logic [3:0] OPC_LM  = 4'b0110;
    localparam logic [3:0] OPC_SM  = 4'b0111;

    typedef struct packed {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic       active;
        logic [2:0] rg;
        logic [3:0] off;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] op;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       u1;
        logic       u2;
        logic [7:0] rl;
        logic       mr;
        logic       rw;
        logic [2:0] rd;
        logic       br;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_opcode = 4'd0;
    logic [2:0]  id_rs1 = 3'd0;
    logic [2:0]  id_rs2 = 3'd0;
    logic        id_use_rs1 = 1'b0;
    logic        id_use_rs2 = 1'b0;
    logic [7:0]  id_reglist = 8'd0;
    logic        ex_memread = 1'b0;
    logic        ex_regwrite = 1'b0;
    logic [2:0]  ex_regdst = 3'd0;
    logic        ex_br_taken = 1'b0;
    logic        stall_pc, bubble_ex, flush_id, lmsm_active, lmsm_last;
    logic [2:0]  lmsm_reg;
    logic [3:0]  lmsm_offset;
    logic [15:0] stall_cnt, flush_cnt;

    int   total = 0;
    int   bad = 0;
    int   exp_sc = 0;
    int   exp_fc = 0;
    exp_t exp_q[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    rd_ex_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_reglist(id_reglist), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_regdst(ex_regdst), .ex_br_taken(ex_br_taken), .stall_pc(stall_pc),
        .bubble_ex(bubble_ex), .flush_id(flush_id), .lmsm_active(lmsm_active),
        .lmsm_reg(lmsm_reg), .lmsm_offset(lmsm_offset), .lmsm_last(lmsm_last),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic exp_t ex(input logic s, input logic b, input logic f, input logic a,
                                input logic [2:0] r, input logic [3:0] o, input logic l);
        exp_t e;
        e.stall = s; e.bubble = b; e.flush = f; e.active = a;
        e.rg = r; e.off = o; e.last = l;
        return e;
    endfunction

    function automatic vec_t vi(input logic valid, input logic [3:0] op,
                                input logic [2:0] rs1, input logic [2:0] rs2,
                                input logic u1, input logic u2, input logic [7:0] rl,
                                input logic mr, input logic rw, input logic [2:0] rd,
                                input logic br, input exp_t e);
        vec_t v;
        v.valid = valid; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rl = rl; v.mr = mr; v.rw = rw; v.rd = rd; v.br = br; v.e = e;
        return v;
    endfunction

    task automatic check_out(input exp_t e, input string nm);
        exp_t got;
        got = {stall_pc, bubble_ex, flush_id, lmsm_active, lmsm_reg, lmsm_offset, lmsm_last};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got stall=%b bub=%b fl=%b act=%b reg=%0d off=%0d last=%b, want stall=%b bub=%b fl=%b act=%b reg=%0d off=%0d last=%b",
                     nm, got.stall, got.bubble, got.flush, got.active, got.rg, got.off, got.last,
                     e.stall, e.bubble, e.flush, e.active, e.rg, e.off, e.last);
        end
    endtask

    task automatic check_cnt(input logic [15:0] got, input logic [15:0] want, input string nm);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Drive one vector after the rising edge, score it on the falling edge.
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        id_valid = v.valid; id_opcode = v.op; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_reglist = v.rl;
        ex_memread = v.mr; ex_regwrite = v.rw; ex_regdst = v.rd; ex_br_taken = v.br;
        exp_q.push_back(v.e);
        if (v.e.stall || (v.e.bubble && !v.e.flush)) exp_sc++;
        if (v.e.flush) exp_fc++;
        @(negedge clk);
        e = exp_q.pop_front();
        check_out(e, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t z;
        z = ex(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0);

        // Load-use detection variants
        vt.push_back(vi(1'b1, OPC_ADD, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd1, 3'd5, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd3, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, z));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, z));
        vt.push_back(vi(1'b0, OPC_ADD, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, z));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd2, 3'd4, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'd3, 1'b0, z));
        // LM 8'b1000_0101, EX load matching base during SEQ is ignored
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h85, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h85, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h85, 1'b1, 1'b1, 3'd1, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'd1, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h85, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 4'd2, 1'b1)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd4, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd4, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd4, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));
        // SM with empty reglist: one bubble, no micro-ops
        vt.push_back(vi(1'b1, OPC_SM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b0, OPC_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));
        // LM 8'hFF aborted by a taken branch on the 2nd micro-op
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b1, ex(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd2, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));
        // Branch and load-use together: flush wins
        vt.push_back(vi(1'b1, OPC_ADD, 3'd3, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, ex(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0)));
        // Branch in IDLE beats LM start
        vt.push_back(vi(1'b1, OPC_LM, 3'd0, 3'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 3'd0, 1'b1, ex(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));
        // Load-use on the LM base delays the start by one cycle
        vt.push_back(vi(1'b1, OPC_LM, 3'd3, 3'd0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 3'd3, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd3, 3'd0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd3, 3'd0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0)));
        vt.push_back(vi(1'b1, OPC_LM, 3'd3, 3'd0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'd1, 1'b1)));
        vt.push_back(vi(1'b1, OPC_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));
        // Full LM 8'hFF: offsets 0..7 back to back
        vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)));
        for (int i = 0; i < 8; i++) begin
            vt.push_back(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0,
                            ex(i != 7, 1'b0, 1'b0, 1'b1, 3'(i), 4'(i), i == 7)));
        end
        vt.push_back(vi(1'b1, OPC_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z));

        // Reset state
        #12;
        check_out(z, "reset_outputs");
        check_cnt(stall_cnt, 16'd0, "reset_stall_cnt");
        check_cnt(flush_cnt, 16'd0, "reset_flush_cnt");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i], $sformatf("vec%0d", i));
        end

`ifdef PIPE_CTRL_PERF_EN
        check_cnt(stall_cnt, 16'(exp_sc), "stall_cnt");
        check_cnt(flush_cnt, 16'(exp_fc), "flush_cnt");
`else
        check_cnt(stall_cnt, 16'd0, "stall_cnt_off");
        check_cnt(flush_cnt, 16'd0, "flush_cnt_off");
`endif

        // Async reset in the middle of an LM sequence
        step(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)), "rst_seq_start");
        step(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 3'd1, 1'b0, ex(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0)), "rst_seq_uop0");
        #2;
        rst_n = 1'b0;
        #1;
        check_out(z, "rst_mid_seq");
        check_cnt(stall_cnt, 16'd0, "rst_mid_stall_cnt");
        check_cnt(flush_cnt, 16'd0, "rst_mid_flush_cnt");
        @(posedge clk);
        #1;
        check_out(z, "rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(vi(1'b1, OPC_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z), "post_rst_idle");
        step(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0)), "post_rst_lm_start");
        step(vi(1'b1, OPC_LM, 3'd1, 3'd0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 1'b0, ex(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b1)), "post_rst_lm_uop");
        step(vi(1'b0, OPC_ADD, 3'd0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, z), "post_rst_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
